// File: rtl/rs_multi_cdb_pkg.sv
// Shared defaults, opcode constants and CDB packing helper for rs_multi_cdb.
// RS_CDB_FIELD(bus, ch, w) selects channel ch of a packed CDB bus.
`ifndef RS_CDB_FIELD
`define RS_CDB_FIELD(bus, ch, w) bus[(ch)*(w) +: (w)]
`endif

package rs_multi_cdb_pkg;
    localparam int RS_DEPTH_DEF = 16;
    localparam int TAG_W_DEF = 4;
    localparam int VAL_W_DEF = 32;
    localparam int OP_W_DEF = 6;
    localparam int CDB_N_DEF = 2;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_SLT = 6'd6;
endpackage

// File: rtl/rs_multi_cdb_age.sv
// Age matrix for rs_multi_cdb: tracks relative entry age, picks the oldest
// requester.
module rs_age_matrix #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 alloc_en,
    input  logic [$clog2(N)-1:0] alloc_idx,
    input  logic [N-1:0]         busy,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant
);
    // older[i][j] set: entry j was allocated before entry i
    logic [N-1:0] older [N];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else if (alloc_en) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i == int'(alloc_idx)) older[i][j] <= busy[j];
                    else if (j == int'(alloc_idx)) older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = req[i] && !(|(older[i] & req));
        end
    end
endmodule

// File: rtl/rs_multi_cdb.sv
// Out-of-order ALU reservation station with CDB_N-channel operand wakeup.
// Define RS_WAKEUP_BYPASS_EN to let same-cycle CDB wakeups dispatch at once.
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int VAL_W = VAL_W_DEF,
    parameter int OP_W = OP_W_DEF,
    parameter int CDB_N = CDB_N_DEF
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic [OP_W-1:0]          issue_op,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic [VAL_W-1:0]         issue_v1,
    input  logic [VAL_W-1:0]         issue_v2,
    input  logic [TAG_W-1:0]         issue_q1,
    input  logic [TAG_W-1:0]         issue_q2,
    input  logic                     issue_r1,
    input  logic                     issue_r2,
    output logic                     full,
    output logic [$clog2(RS_DEPTH):0] count,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]   cdb_tag,
    input  logic [CDB_N*VAL_W-1:0]   cdb_val,
    output logic                     disp_valid,
    input  logic                     disp_ready,
    output logic [OP_W-1:0]          disp_op,
    output logic [TAG_W-1:0]         disp_tag,
    output logic [VAL_W-1:0]         disp_v1,
    output logic [VAL_W-1:0]         disp_v2
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Returns {hit, value}; the lowest matching channel wins.
    function automatic logic [VAL_W:0] lookup(
        input logic [TAG_W-1:0]       q,
        input logic [CDB_N-1:0]       vld,
        input logic [CDB_N*TAG_W-1:0] tags,
        input logic [CDB_N*VAL_W-1:0] vals
    );
        logic [VAL_W:0] res;
        res = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (vld[c] && `RS_CDB_FIELD(tags, c, TAG_W) == q) begin
                res = {1'b1, `RS_CDB_FIELD(vals, c, VAL_W)};
            end
        end
        return res;
    endfunction

    logic [RS_DEPTH-1:0] busy, r1, r2;
    logic [OP_W-1:0]     op [RS_DEPTH];
    logic [TAG_W-1:0]    tag [RS_DEPTH];
    logic [TAG_W-1:0]    q1 [RS_DEPTH];
    logic [TAG_W-1:0]    q2 [RS_DEPTH];
    logic [VAL_W-1:0]    v1 [RS_DEPTH];
    logic [VAL_W-1:0]    v2 [RS_DEPTH];

    logic [VAL_W:0]      w1 [RS_DEPTH];
    logic [VAL_W:0]      w2 [RS_DEPTH];
    logic [VAL_W:0]      iw1, iw2;
    logic [RS_DEPTH-1:0] er1, er2, eligible, grant;
    logic [VAL_W-1:0]    ev1 [RS_DEPTH];
    logic [VAL_W-1:0]    ev2 [RS_DEPTH];
    logic [IDX_W-1:0]    free_idx;
    logic [CNT_W-1:0]    cnt;
    logic                issue_go, disp_go;

    always_comb begin
        iw1 = lookup(issue_q1, cdb_valid, cdb_tag, cdb_val);
        iw2 = lookup(issue_q2, cdb_valid, cdb_tag, cdb_val);
        for (int i = 0; i < RS_DEPTH; i++) begin
            w1[i] = lookup(q1[i], cdb_valid, cdb_tag, cdb_val);
            w2[i] = lookup(q2[i], cdb_valid, cdb_tag, cdb_val);
`ifdef RS_WAKEUP_BYPASS_EN
            er1[i] = r1[i] | w1[i][VAL_W];
            er2[i] = r2[i] | w2[i][VAL_W];
            ev1[i] = r1[i] ? v1[i] : w1[i][VAL_W-1:0];
            ev2[i] = r2[i] ? v2[i] : w2[i][VAL_W-1:0];
`else
            er1[i] = r1[i];
            er2[i] = r2[i];
            ev1[i] = v1[i];
            ev2[i] = v2[i];
`endif
        end
    end

    assign eligible = busy & er1 & er2;

    always_comb begin
        free_idx = '0;
        cnt = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_DEPTH; i++) cnt = cnt + CNT_W'(busy[i]);
    end

    assign count = cnt;
    assign full = (cnt == CNT_W'(RS_DEPTH));
    assign disp_valid = (|eligible) && rdy_in && !flush;
    assign disp_go = disp_valid && disp_ready;
    assign issue_go = rdy_in && issue_valid && !full && !flush;

    // grant is one-hot or zero, so an OR-mux suffices
    always_comb begin
        disp_op = '0;
        disp_tag = '0;
        disp_v1 = '0;
        disp_v2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                disp_op = disp_op | op[i];
                disp_tag = disp_tag | tag[i];
                disp_v1 = disp_v1 | ev1[i];
                disp_v2 = disp_v2 | ev2[i];
            end
        end
    end

    rs_age_matrix #(.N(RS_DEPTH)) u_age (
        .clk       (clk),
        .rst       (rst_in),
        .clr       (rdy_in && flush),
        .alloc_en  (issue_go),
        .alloc_idx (free_idx),
        .busy      (busy),
        .req       (eligible),
        .grant     (grant)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            busy <= '0;
            r1 <= '0;
            r2 <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy[i] && !r1[i] && w1[i][VAL_W]) begin
                        r1[i] <= 1'b1;
                        v1[i] <= w1[i][VAL_W-1:0];
                    end
                    if (busy[i] && !r2[i] && w2[i][VAL_W]) begin
                        r2[i] <= 1'b1;
                        v2[i] <= w2[i][VAL_W-1:0];
                    end
                    if (disp_go && grant[i]) busy[i] <= 1'b0;
                end
                if (issue_go) begin
                    busy[free_idx] <= 1'b1;
                    op[free_idx] <= issue_op;
                    tag[free_idx] <= issue_tag;
                    q1[free_idx] <= issue_q1;
                    q2[free_idx] <= issue_q2;
                    r1[free_idx] <= issue_r1 | iw1[VAL_W];
                    r2[free_idx] <= issue_r2 | iw2[VAL_W];
                    v1[free_idx] <= issue_r1 ? issue_v1 : iw1[VAL_W-1:0];
                    v2[free_idx] <= issue_r2 ? issue_v2 : iw2[VAL_W-1:0];
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic dup_tag;
    always_comb begin
        dup_tag = 1'b0;
        for (int a = 0; a < CDB_N; a++) begin
            for (int b = a + 1; b < CDB_N; b++) begin
                if (cdb_valid[a] && cdb_valid[b] &&
                    `RS_CDB_FIELD(cdb_tag, a, TAG_W) ==
                    `RS_CDB_FIELD(cdb_tag, b, TAG_W)) dup_tag = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_in && rdy_in) begin
            assert (!(issue_valid && full && !flush))
                else $warning("rs_multi_cdb: issue while full dropped");
            assert (!dup_tag)
                else $warning("rs_multi_cdb: same tag on two CDB channels");
        end
    end
`endif
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed table-driven bench for rs_multi_cdb plus fill and flush sequences.
module tb_rs_multi_cdb;
    import rs_multi_cdb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush, issue_valid, issue_r1, issue_r2;
    logic [5:0]  issue_op;
    logic [3:0]  issue_tag, issue_q1, issue_q2;
    logic [31:0] issue_v1, issue_v2;
    logic        full, disp_valid, disp_ready;
    logic [4:0]  count;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic [5:0]  disp_op;
    logic [3:0]  disp_tag;
    logic [31:0] disp_v1, disp_v2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rs_multi_cdb dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_tag(issue_tag), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .issue_r1(issue_r1), .issue_r2(issue_r2),
        .full(full), .count(count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_tag(disp_tag),
        .disp_v1(disp_v1), .disp_v2(disp_v2)
    );

    typedef struct {
        logic        frz;
        logic        iv;
        logic [5:0]  op;
        logic [3:0]  tag, q1, q2;
        logic        r1, r2;
        logic [31:0] v1, v2;
        logic [1:0]  cv;
        logic [7:0]  ctag;
        logic [63:0] cval;
        logic        drdy;
        logic        e_dv;
        logic [5:0]  e_op;
        logic [3:0]  e_tag;
        logic [31:0] e_v1, e_v2;
        logic [4:0]  e_cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_op = '0;
        issue_tag = '0;
        issue_q1 = '0;
        issue_q2 = '0;
        issue_v1 = '0;
        issue_v2 = '0;
        issue_r1 = 1'b0;
        issue_r2 = 1'b0;
        cdb_valid = '0;
        cdb_tag = '0;
        cdb_val = '0;
        disp_ready = 1'b0;
    endtask

    task automatic issue_rdy(input logic [3:0] t, input logic [31:0] a,
                             input logic [31:0] b);
        issue_valid = 1'b1;
        issue_op = OP_ADD;
        issue_tag = t;
        issue_v1 = a;
        issue_v2 = b;
        issue_r1 = 1'b1;
        issue_r2 = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        rdy_in = !v.frz;
        flush = 1'b0;
        issue_valid = v.iv;
        issue_op = v.op;
        issue_tag = v.tag;
        issue_q1 = v.q1;
        issue_q2 = v.q2;
        issue_r1 = v.r1;
        issue_r2 = v.r2;
        issue_v1 = v.v1;
        issue_v2 = v.v2;
        cdb_valid = v.cv;
        cdb_tag = v.ctag;
        cdb_val = v.cval;
        disp_ready = v.drdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{default: 0};
        tv[1] = '{iv: 1, op: OP_ADD, tag: 3, v1: 5, v2: 7, r1: 1, r2: 1,
                  default: 0};
        tv[2] = '{drdy: 1, e_dv: 1, e_op: OP_ADD, e_tag: 3, e_v1: 5,
                  e_v2: 7, e_cnt: 1, default: 0};
        tv[3] = '{default: 0};
        tv[4] = '{iv: 1, op: OP_ADD, tag: 1, q1: 9, v2: 32'h22, r2: 1,
                  default: 0};
        tv[5] = '{iv: 1, op: OP_AND, tag: 2, v1: 32'h10, v2: 32'h20,
                  r1: 1, r2: 1, e_cnt: 1, default: 0};
`ifdef RS_WAKEUP_BYPASS_EN
        tv[6] = '{cv: 2'b10, ctag: 8'h99, cval: 64'h00001234_0000dead,
                  drdy: 1, e_dv: 1, e_op: OP_ADD, e_tag: 1,
                  e_v1: 32'h1234, e_v2: 32'h22, e_cnt: 2, default: 0};
        tv[7] = '{drdy: 1, e_dv: 1, e_op: OP_AND, e_tag: 2, e_v1: 32'h10,
                  e_v2: 32'h20, e_cnt: 1, default: 0};
`else
        tv[6] = '{cv: 2'b10, ctag: 8'h99, cval: 64'h00001234_0000dead,
                  drdy: 1, e_dv: 1, e_op: OP_AND, e_tag: 2, e_v1: 32'h10,
                  e_v2: 32'h20, e_cnt: 2, default: 0};
        tv[7] = '{drdy: 1, e_dv: 1, e_op: OP_ADD, e_tag: 1,
                  e_v1: 32'h1234, e_v2: 32'h22, e_cnt: 1, default: 0};
`endif
        tv[8] = '{default: 0};
        tv[9] = '{iv: 1, op: OP_OR, tag: 4, v1: 1, v2: 2, r1: 1, r2: 1,
                  default: 0};
        tv[10] = '{iv: 1, op: OP_XOR, tag: 5, v1: 3, v2: 4, r1: 1, r2: 1,
                   e_dv: 1, e_op: OP_OR, e_tag: 4, e_v1: 1, e_v2: 2,
                   e_cnt: 1, default: 0};
        tv[11] = '{e_dv: 1, e_op: OP_OR, e_tag: 4, e_v1: 1, e_v2: 2,
                   e_cnt: 2, default: 0};
        tv[12] = tv[11];
        tv[13] = '{drdy: 1, e_dv: 1, e_op: OP_OR, e_tag: 4, e_v1: 1,
                   e_v2: 2, e_cnt: 2, default: 0};
        tv[14] = '{drdy: 1, e_dv: 1, e_op: OP_XOR, e_tag: 5, e_v1: 3,
                   e_v2: 4, e_cnt: 1, default: 0};
        tv[15] = '{default: 0};
        tv[16] = '{iv: 1, op: OP_SUB, tag: 7, v1: 11, r1: 1, q2: 6,
                   cv: 2'b01, ctag: 8'h06, cval: 64'd42, default: 0};
        tv[17] = '{cv: 2'b10, ctag: 8'h60, cval: 64'h00000063_00000000,
                   drdy: 1, e_dv: 1, e_op: OP_SUB, e_tag: 7, e_v1: 11,
                   e_v2: 42, e_cnt: 1, default: 0};
        tv[18] = '{default: 0};
        tv[19] = '{iv: 1, op: OP_SLT, tag: 8, v1: 1, v2: 1, r1: 1, r2: 1,
                   default: 0};
        tv[20] = '{frz: 1, iv: 1, op: OP_ADD, tag: 9, v1: 2, v2: 2, r1: 1,
                   r2: 1, drdy: 1, e_cnt: 1, default: 0};
        tv[21] = '{drdy: 1, e_dv: 1, e_op: OP_SLT, e_tag: 8, e_v1: 1,
                   e_v2: 1, e_cnt: 1, default: 0};
        tv[22] = '{default: 0};
        tv[23] = '{iv: 1, op: OP_ADD, tag: 0, q1: 0, v2: 3, r2: 1,
                   default: 0};
`ifdef RS_WAKEUP_BYPASS_EN
        tv[24] = '{cv: 2'b01, ctag: 8'h00, cval: 64'h55, drdy: 1, e_dv: 1,
                   e_op: OP_ADD, e_tag: 0, e_v1: 32'h55, e_v2: 3, e_cnt: 1,
                   default: 0};
        tv[25] = '{drdy: 1, default: 0};
`else
        tv[24] = '{cv: 2'b01, ctag: 8'h00, cval: 64'h55, drdy: 1, e_cnt: 1,
                   default: 0};
        tv[25] = '{drdy: 1, e_dv: 1, e_op: OP_ADD, e_tag: 0, e_v1: 32'h55,
                   e_v2: 3, e_cnt: 1, default: 0};
`endif
        tv[26] = '{default: 0};

        idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_dv", 64'(disp_valid), 64'd0);
        chk("rst_disp", {disp_op, disp_tag, disp_v1[15:0], disp_v2[15:0]},
            64'd0);
        tick();

        for (int k = 0; k < NV; k++) begin
            apply(tv[k]);
            #1;
            chk($sformatf("row%0d_dv", k), 64'(disp_valid), 64'(tv[k].e_dv));
            chk($sformatf("row%0d_cnt", k), 64'(count), 64'(tv[k].e_cnt));
            chk($sformatf("row%0d_full", k), 64'(full),
                64'(tv[k].e_cnt == 5'd16));
            if (tv[k].e_dv) begin
                chk($sformatf("row%0d_op", k), 64'(disp_op), 64'(tv[k].e_op));
                chk($sformatf("row%0d_tag", k), 64'(disp_tag),
                    64'(tv[k].e_tag));
                chk($sformatf("row%0d_v1", k), 64'(disp_v1), 64'(tv[k].e_v1));
                chk($sformatf("row%0d_v2", k), 64'(disp_v2), 64'(tv[k].e_v2));
            end
            tick();
        end

        // fill all 16 slots, then try one more while dispatching the oldest
        for (int i = 0; i < 16; i++) begin
            idle();
            issue_rdy(4'(i), 32'(i), 32'(i + 100));
            #1;
            chk("fill_cnt", 64'(count), 64'(i));
            tick();
        end
        idle();
        #1;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_cnt16", 64'(count), 64'd16);
        chk("fill_dv", 64'(disp_valid), 64'd1);
        chk("fill_oldest", 64'(disp_tag), 64'd0);
        issue_rdy(4'hA, 32'hbad, 32'hbad);
        disp_ready = 1'b1;
        #1;
        chk("extra_full", 64'(full), 64'd1);
        tick();
        idle();
        #1;
        chk("after_disp_full", 64'(full), 64'd0);
        chk("after_disp_cnt", 64'(count), 64'd15);
        for (int i = 1; i < 16; i++) begin
            disp_ready = 1'b1;
            #1;
            chk("drain_tag", 64'(disp_tag), 64'(i));
            chk("drain_v2", 64'(disp_v2), 64'(i + 100));
            tick();
        end
        idle();
        #1;
        chk("drain_empty", 64'(count), 64'd0);
        chk("drain_dv", 64'(disp_valid), 64'd0);

        // flush with concurrent issue and dispatch
        for (int i = 0; i < 8; i++) begin
            idle();
            issue_rdy(4'(i + 1), 32'(i), 32'(i));
            tick();
        end
        idle();
        #1;
        chk("pre_flush_cnt", 64'(count), 64'd8);
        issue_rdy(4'hF, 32'h1, 32'h1);
        disp_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_dv", 64'(disp_valid), 64'd0);
        tick();
        idle();
        #1;
        chk("post_flush_cnt", 64'(count), 64'd0);
        chk("post_flush_dv", 64'(disp_valid), 64'd0);
        issue_rdy(4'hC, 32'h77, 32'h88);
        tick();
        idle();
        disp_ready = 1'b1;
        #1;
        chk("post_flush_issue_cnt", 64'(count), 64'd1);
        chk("post_flush_issue_tag", 64'(disp_tag), 64'hC);
        chk("post_flush_issue_v1", 64'(disp_v1), 64'h77);
        tick();
        idle();
        #1;
        chk("final_cnt", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
Parametrised out-of-order reservation station for the integer ALU path, the next generation of the single-CDB station. Holds up to RS_DEPTH renamed instructions. Wakes operands from CDB_N parallel CDB channels and dispatches the oldest ready entry to the ALU over a valid/ready handshake. Sits between decoder/ROB issue logic and the ALU; results return via CDB, not through this block.

Parameters:
RS_DEPTH, 16, number of entries (power of two, >=2)
TAG_W, 4, ROB index width
VAL_W, 32, operand width
OP_W, 6, opcode field width
CDB_N, 2, number of CDB broadcast channels

Ports:
clk  in  1  clock, all state updates on posedge
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = freeze all state
flush  in  1  misprediction flush, synchronous, qualified by rdy_in
issue_valid  in  1  new instruction present
issue_op  in  OP_W  opcode
issue_tag  in  TAG_W  destination ROB index
issue_v1/issue_v2  in  VAL_W  operand values (valid when matching rdy bit high)
issue_q1/issue_q2  in  TAG_W  producer ROB index when not ready
issue_r1/issue_r2  in  1  operand already available
full  out  1  no free entry
count  out  $clog2(RS_DEPTH)+1  occupied entries
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_tag  in  CDB_N*TAG_W  packed tags, channel 0 in LSBs
cdb_val  in  CDB_N*VAL_W  packed values
disp_valid  out  1  entry offered to ALU
disp_ready  in  1  ALU accepts
disp_op/disp_tag/disp_v1/disp_v2  out  OP_W/TAG_W/VAL_W/VAL_W  dispatched fields

Behaviour:
- Reset (rst_in=1 at posedge): all busy bits 0, age matrix cleared; full=0, count=0, disp_valid=0, disp_* = 0.
- Tag 0 is a legal ROB index; dependency is indicated solely by r1/r2 bits.
- Issue: when rdy_in & issue_valid & !full, write the lowest-index free entry; set its age row older-than every busy entry. issue_valid while full is a protocol violation and is ignored (assertion).
- Issue-time capture: if an operand is not ready and its q matches any valid CDB channel in the same cycle, store the value as ready.
- Wakeup: each busy, not-ready operand compares against all CDB_N channels each cycle; on match, latch value and set ready. Multiple channels with the same tag: lowest channel index wins (assertion flags it).
- Select: eligible = busy & r1 & r2. disp_valid = any eligible & rdy_in & !flush; disp_* from the oldest eligible entry (age matrix). Combinational from registered state.
- Dispatch: on disp_valid & disp_ready at posedge, the selected entry's busy bit clears. disp_* must stay stable while disp_valid & !disp_ready, unless an older entry becomes eligible (then the selection switches; ALU must sample only on handshake).
- Simultaneous issue and dispatch allowed; full/count reflect pre-edge state (a slot freed this cycle is not reused until next cycle).
- Latency: issued fully-ready entry may dispatch the cycle after issue; CDB-woken entry dispatches the cycle after wakeup.
- flush (with rdy_in): all busy cleared next edge; flush overrides issue and dispatch in the same cycle. rst_in overrides everything.
- rdy_in=0: no state change, disp_valid=0.

Optional Feature:
RS_WAKEUP_BYPASS_EN: when defined, an entry whose last operand is woken by CDB this cycle is eligible the same cycle, with disp_v1/v2 muxed from cdb_val (saves one cycle; longer path). When undefined, eligibility uses registered ready bits only.

Decomposition:
- Shared package/include: TAG_W, VAL_W, OP_W defaults, opcode constants, CDB packing helper macros.
- Sub-module rs_age_matrix (RS_DEPTH×RS_DEPTH bit matrix: allocate, free, oldest-of-request-vector).

Test Plan:
- Reset then issue op=ADD tag=3, v1=5, v2=7 both ready -> next cycle disp_valid=1, disp_tag=3, v1=5, v2=7; with disp_ready=1, count returns 0.
- Issue tag=1 waiting on q1=9, then tag=2 ready; CDB ch1 tag=9 val=0x1234 -> tag=2 dispatches first, tag=1 dispatches next cycle with v1=0x1234 (same cycle when RS_WAKEUP_BYPASS_EN).
- Two ready entries issued tag=4 then tag=5, disp_ready held 0 for 3 cycles -> disp_tag stays 4; on accept, tag=5 offered next.
- Fill 16 entries -> full=1, count=16; extra issue ignored; dispatch one -> full=0 the following cycle.
- Issue q2=6 while CDB ch0 tag=6 val=42 same cycle -> entry ready, disp_v2=42.
- With 8 entries busy, assert flush with issue_valid and disp_ready -> next cycle count=0, disp_valid=0, no new entry.
